// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and defaults for the bit-serial subtractor
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle between a requester and the serial subtractor
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor_sub_bit_cell.sv
// rtl/serial_subtractor_sub_bit_cell.sv - combinational 1-bit full subtractor x - y - bi
module sub_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - computes a - b - bin one bit per clock, LSB first, via one subtractor cell
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             bout_q;
    logic             d;
    logic             bo;

    sub_bit_cell u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (br),
        .d  (d),
        .bo (bo)
    );

    // Difference bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    always_comb begin
        res_next            = res_sr >> 1;
        res_next[WIDTH-1]   = d;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (cnt == LAST_BIT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        br     <= bus.bin;
                        cnt    <= '0;
                        res_sr <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= bo;
                    res_sr <= res_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        diff_q <= res_next;
                        bout_q <= bo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor with randomized operands
module tb_serial_subtractor;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer subtraction; a negative result means a borrow out.
    function automatic exp_t model(input int av, input int bv, input int bi, input int c);
        exp_t e;
        int   r;
        r      = av - bv - bi;
        e.diff = W'(r & ((1 << W) - 1));
        e.bout = (r < 0);
        e.cyc  = c + W;
        return e;
    endfunction

    int last_accept = 0;

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input bit keep);
        int guard = 0;
        @(negedge clk);
        while (bus.busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("idle_timeout", 32'(guard), 32'd0);
        bus.a     = av;
        bus.b     = bv;
        bus.bin   = bi;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        sb_q.push_back(model(int'(av), int'(bv), int'(bi), cyc));
        last_accept = cyc;
        bus.a   = W'($urandom);
        bus.b   = W'($urandom);
        bus.bin = 1'($urandom_range(0, 1));
        if (!keep) bus.start = 1'b0;
    endtask

    logic [W-1:0] prev_diff = '0;
    logic         prev_bout = 1'b0;
    int           run_len = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_diff = '0;
            prev_bout = 1'b0;
            run_len   = 0;
        end else begin
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("diff", 32'(bus.diff), 32'(e.diff));
                    chk("bout", 32'(bus.bout), 32'(e.bout));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                end
                prev_diff = bus.diff;
                prev_bout = bus.bout;
            end else begin
                chk("diff_hold", 32'(bus.diff), 32'(prev_diff));
                chk("bout_hold", 32'(bus.bout), 32'(prev_bout));
            end
            if (bus.busy) begin
                run_len++;
            end else if (run_len != 0) begin
                chk("busy_len", 32'(run_len), 32'(W + 1));
                run_len = 0;
            end
        end
    end

    initial begin
        int prev_acc;
        int guard;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_bout", 32'(bus.bout), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);

        issue(8'h5A, 8'h3C, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        bus.a     = 8'h10;
        bus.b     = 8'h01;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        issue(8'h00, 8'h01, 1'b0, 1'b0);
        issue(8'h00, 8'h00, 1'b1, 1'b0);
        issue(8'h80, 8'h7F, 1'b1, 1'b0);
        issue(8'hFF, 8'hFF, 1'b0, 1'b0);

        // Start held high: back-to-back accepts must be WIDTH+2 cycles apart.
        issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 3; i++) begin
            prev_acc = last_accept;
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            chk("issue_interval", 32'(last_accept - prev_acc), 32'(W + 2));
        end
        bus.start = 1'b0;

        for (int i = 0; i < 20; i++)
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);

        issue(8'h33, 8'h11, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_diff", 32'(bus.diff), 32'd0);
        chk("abort_bout", 32'(bus.bout), 32'd0);
        void'(sb_q.pop_back());
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(8'h05, 8'h07, 1'b0, 1'b0);

        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
